// File: rtl/vscale_fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package vscale_fetch_unit_pkg;

  localparam int unsigned FETCH_STATE_WIDTH = 2;
  localparam int unsigned INST_LEN          = 32;
  localparam logic [INST_LEN-1:0] RV_NOP    = 32'h0000_0013;

  typedef enum logic [FETCH_STATE_WIDTH-1:0] {
    FETCH_REQ   = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/vscale_fetch_unit_if.sv
// Instruction-memory request/response channel between fetch (master) and imem (slave).
interface vscale_fetch_unit_if #(
  parameter int unsigned XPR_LEN = 32
);
  import vscale_fetch_unit_pkg::*;

  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [XPR_LEN-1:0]  imem_addr;
  logic                imem_resp_valid;
  logic [INST_LEN-1:0] imem_resp_data;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data
  );

endinterface

// File: rtl/vscale_fetch_skid_buf.sv
// One-entry {inst, PC} holding buffer that absorbs a response arriving while DX is stalled.
module vscale_fetch_skid_buf #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic         drain,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full
);

  logic         full_q;
  logic [W-1:0] data_q;

  // Clear/drain win over load; fetch never loads while the entry is occupied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      if (clear || drain) begin
        full_q <= 1'b0;
      end else if (load) begin
        full_q <= 1'b1;
      end
      if (load) begin
        data_q <= din;
      end
    end
  end

  assign dout = data_q;
  assign full = full_q;

endmodule

// File: rtl/vscale_fetch_unit.sv
// Fetch stage: registers PC_IF, runs the single-outstanding imem handshake and feeds DX.
module vscale_fetch_unit
  import vscale_fetch_unit_pkg::*;
#(
  parameter int unsigned        XPR_LEN  = 32,
  parameter logic [XPR_LEN-1:0] RESET_PC = XPR_LEN'(32'h0000_0200)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [XPR_LEN-1:0]  PC_PIF,
  input  logic                kill_IF,
  input  logic                flush_DX,
  input  logic                stall_DX,
  vscale_fetch_unit_if.master imem,
  output logic [XPR_LEN-1:0]  PC_IF,
  output logic                replay_IF,
  output logic [INST_LEN-1:0] inst_DX,
  output logic [XPR_LEN-1:0]  PC_DX,
  output logic                valid_DX
);

  localparam int unsigned PKT_W = INST_LEN + XPR_LEN;

  fetch_state_e        state_q, state_d;
  logic [XPR_LEN-1:0]  pc_if_q, pc_if_d;
  logic                valid_dx_q, valid_dx_d;
  logic [INST_LEN-1:0] inst_dx_q, inst_dx_d;
  logic [XPR_LEN-1:0]  pc_dx_q, pc_dx_d;

  logic                req_valid;
  logic                advance;
  logic                buf_load, buf_clear, buf_drain, buf_full;
  logic [PKT_W-1:0]    buf_dout;

  vscale_fetch_skid_buf #(.W(PKT_W)) u_skid_buf (
    .clk   (clk),
    .reset (reset),
    .load  (buf_load),
    .clear (buf_clear),
    .drain (buf_drain),
    .din   ({imem.imem_resp_data, pc_if_q}),
    .dout  (buf_dout),
    .full  (buf_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH_REQ;
      pc_if_q    <= RESET_PC;
      valid_dx_q <= 1'b0;
      inst_dx_q  <= RV_NOP;
      pc_dx_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_if_q    <= pc_if_d;
      valid_dx_q <= valid_dx_d;
      inst_dx_q  <= inst_dx_d;
      pc_dx_q    <= pc_dx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_valid  = 1'b0;
    advance    = 1'b0;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    buf_drain  = 1'b0;
    valid_dx_d = valid_dx_q;
    inst_dx_d  = inst_dx_q;
    pc_dx_d    = pc_dx_q;

    // A response seen in REQ belongs to no live request and is dropped.
    unique case (state_q)
      FETCH_REQ: begin
        req_valid = !buf_full && !reset;
        if (req_valid && imem.imem_req_ready) begin
          state_d = kill_IF ? FETCH_DRAIN : FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (imem.imem_resp_valid) begin
          state_d = FETCH_REQ;
          advance = !kill_IF;
        end else if (kill_IF) begin
          state_d = FETCH_DRAIN;
        end
      end
      FETCH_DRAIN: begin
        if (imem.imem_resp_valid) begin
          state_d = FETCH_REQ;
        end
      end
      default: state_d = FETCH_REQ;
    endcase

    pc_if_d = (advance || kill_IF) ? PC_PIF : pc_if_q;

    // A stalled redirecting branch stays in DX; only the IF side is squashed.
    if (flush_DX) begin
      valid_dx_d = 1'b0;
      buf_clear  = 1'b1;
    end else if (kill_IF) begin
      buf_clear = 1'b1;
      if (!stall_DX) begin
        valid_dx_d = 1'b0;
      end
    end else if (!stall_DX) begin
      if (buf_full) begin
        {inst_dx_d, pc_dx_d} = buf_dout;
        valid_dx_d           = 1'b1;
        buf_drain            = 1'b1;
      end else if (advance) begin
        inst_dx_d  = imem.imem_resp_data;
        pc_dx_d    = pc_if_q;
        valid_dx_d = 1'b1;
      end else begin
        valid_dx_d = 1'b0;
      end
    end else if (advance) begin
      buf_load = 1'b1;
    end
  end

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_addr      = pc_if_q;
  assign PC_IF               = pc_if_q;
  assign replay_IF           = !(advance || kill_IF);
  assign inst_DX             = inst_dx_q;
  assign PC_DX               = pc_dx_q;
  assign valid_DX            = valid_dx_q;

endmodule
